// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse program-mode controller: state
// encoding, default timing, and the idle/safe pin values.
package efuse_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CS_SETUP  = 3'd1,
        PGM_SETUP = 3'd2,
        BIT_LOW   = 3'd3,
        BIT_HIGH  = 3'd4,
        PGM_HOLD  = 3'd5,
        CS_HOLD   = 3'd6,
        DONE      = 3'd7
    } efuse_state_t;

    // Default timing in clk_1M cycles (1 cycle = 1 us)
    localparam int DEF_SETUP_CYC    = 2;
    localparam int DEF_SCLK_LOW_CYC = 2;
    localparam int DEF_PGM_HIGH_CYC = 8;
    localparam int DEF_NBITS        = 32;

    // Safe pin bundle: macro deselected, no program mode, strobe low
    localparam logic SAFE_CSB  = 1'b1;
    localparam logic SAFE_PGM  = 1'b0;
    localparam logic SAFE_SCLK = 1'b0;
    localparam logic SAFE_DIN  = 1'b0;

    // A zero-length phase still has to occupy one cycle
    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/efuse_program_mode.sv
// One-shot eFuse burner: after reset release, latches program_bit and
// serially strobes every bit (LSB first) into a 32x1 eFuse macro.
module efuse_program_mode
    import efuse_pkg::*;
#(
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int SCLK_LOW_CYC = DEF_SCLK_LOW_CYC,
    parameter int PGM_HIGH_CYC = DEF_PGM_HIGH_CYC,
    parameter int NBITS        = DEF_NBITS
) (
    input  logic             clk_1M,
    input  logic             rst,
    input  logic [NBITS-1:0] program_bit,
    output logic             CSB,
    output logic             PGM,
    output logic             SCLK,
    output logic             DIN,
    input  logic             DOUT
);

    localparam int SETUP_N = at_least_one(SETUP_CYC);
    localparam int LOW_N   = at_least_one(SCLK_LOW_CYC);
    localparam int HIGH_N  = at_least_one(PGM_HIGH_CYC);
    localparam int MAX_N   = (SETUP_N > LOW_N) ?
                             ((SETUP_N > HIGH_N) ? SETUP_N : HIGH_N) :
                             ((LOW_N > HIGH_N) ? LOW_N : HIGH_N);
    localparam int CW      = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int IW      = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_N - 1);
    localparam logic [CW-1:0] LOW_LAST   = CW'(LOW_N - 1);
    localparam logic [CW-1:0] HIGH_LAST  = CW'(HIGH_N - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NBITS - 1);

    efuse_state_t     r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [NBITS-1:0] r_shadow;
    logic             r_csb;
    logic             r_pgm;
    logic             r_sclk;
    logic             r_din;

    // DOUT carries read data only; nothing in program mode looks at it
    logic w_dout_unused;
    assign w_dout_unused = DOUT;

    assign CSB  = r_csb;
    assign PGM  = r_pgm;
    assign SCLK = r_sclk;
    assign DIN  = r_din;

    // Sequencer: pins are updated on the same edge as the state change,
    // so every output is a flop and SCLK/CSB/PGM cannot glitch
    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_csb    <= SAFE_CSB;
            r_pgm    <= SAFE_PGM;
            r_sclk   <= SAFE_SCLK;
            r_din    <= SAFE_DIN;
        end else begin
            case (r_state)
                IDLE: begin
                    r_shadow <= program_bit;
                    r_cnt    <= '0;
                    r_csb    <= 1'b0;
                    r_state  <= CS_SETUP;
                end
                CS_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_pgm   <= 1'b1;
                        r_state <= PGM_SETUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PGM_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_din   <= r_shadow[0];
                        r_state <= BIT_LOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BIT_LOW: begin
                    if (r_cnt == LOW_LAST) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= BIT_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if (r_cnt == HIGH_LAST) begin
                        r_cnt  <= '0;
                        r_sclk <= 1'b0;
                        if (r_idx == IDX_LAST) begin
                            r_din   <= 1'b0;
                            r_pgm   <= 1'b0;
                            r_state <= PGM_HOLD;
                        end else begin
                            // DIN moves only together with SCLK falling
                            r_idx   <= r_idx + 1'b1;
                            r_din   <= r_shadow[r_idx + 1'b1];
                            r_state <= BIT_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PGM_HOLD: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_csb   <= 1'b1;
                        r_state <= CS_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // One burn per reset: park with safe pin values
                    r_csb  <= SAFE_CSB;
                    r_pgm  <= SAFE_PGM;
                    r_sclk <= SAFE_SCLK;
                    r_din  <= SAFE_DIN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_program_mode.sv
// Bench for efuse_program_mode: directed burns plus random words, each
// checked cycle by cycle against a timeline model of the pin bundle.
module tb_efuse_program_mode;

    logic        clk_1M;
    logic        rst;
    logic [31:0] program_bit;
    logic        CSB, PGM, SCLK, DIN;
    logic        DOUT;

    int ncmp  = 0;
    int nfail = 0;
    int cur_k = 0;

    efuse_program_mode dut (
        .clk_1M      (clk_1M),
        .rst         (rst),
        .program_bit (program_bit),
        .CSB         (CSB),
        .PGM         (PGM),
        .SCLK        (SCLK),
        .DIN         (DIN),
        .DOUT        (DOUT)
    );

    initial clk_1M = 1'b0;
    always #500 clk_1M = ~clk_1M;

    // Expected {CSB,PGM,SCLK,DIN} after k rising edges since release.
    // Timeline: 2 CS setup, 2 PGM setup, 32 x (2 low + 8 high),
    // 2 PGM hold, 2 CS hold, then parked.
    function automatic logic [3:0] model(input logic [31:0] w, input int k);
        int t = k - 1;
        int b, p;
        if (t < 2)   return 4'b0000;
        if (t < 4)   return 4'b0100;
        if (t < 324) begin
            b = (t - 4) / 10;
            p = (t - 4) % 10;
            return {1'b0, 1'b1, (p >= 2), w[b]};
        end
        if (t < 326) return 4'b0000;
        return 4'b1000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, cur_k, obs, exp);
        end
    endtask

    // Hold reset one cycle, check safe pins, then release and follow the
    // burn for ncyc edges. swap: overwrite program_bit after pulse 5.
    task automatic burn(input logic [31:0] w, input int ncyc, input bit swap);
        logic [31:0] q;
        int          pulses;
        logic        psclk, pdin;
        @(negedge clk_1M);
        rst = 1'b0;
        program_bit = w;
        cur_k = 0;
        #1 chk("rst_pins", {28'd0, CSB, PGM, SCLK, DIN}, 32'h8);
        @(negedge clk_1M);
        rst = 1'b1;
        q = '0; pulses = 0; psclk = 1'b0; pdin = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk_1M);
            #1;
            cur_k = k;
            chk("pins", {28'd0, CSB, PGM, SCLK, DIN}, {28'd0, model(w, k)});
            if (psclk && SCLK && (DIN !== pdin))
                chk("din_stable_hi", {31'd0, DIN}, {31'd0, pdin});
            if (SCLK && !psclk) begin
                if (pulses < 32) q[pulses] = DIN;
                pulses++;
            end
            if (swap && pulses == 5 && !SCLK && psclk) program_bit = 32'hFFFF_FFFF;
            psclk = SCLK;
            pdin  = DIN;
        end
        if (ncyc >= 330) begin
            chk("pulse_count", pulses, 32);
            chk("fuse_q", q, w);
        end
    endtask

    initial begin
        rst = 1'b0;
        DOUT = 1'b0;
        program_bit = '0;
        #1700;
        chk("reset_state", {28'd0, CSB, PGM, SCLK, DIN}, 32'h8);

        // basic burn with late data change, then a long parked tail
        burn(32'h5555_AAAA, 1330, 1'b1);

        // abort inside bit 10 program pulse, then restart with a new word
        burn($urandom, 110, 1'b0);
        #200;
        rst = 1'b0;
        #1;
        chk("async_abort", {28'd0, CSB, PGM, SCLK, DIN}, 32'h8);
        burn(32'h1234_5678, 335, 1'b0);

        // edge words
        burn(32'h0000_0000, 335, 1'b0);
        burn(32'hFFFF_FFFF, 335, 1'b0);

        // random words
        for (int i = 0; i < 3; i++) burn($urandom, 335, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
